modex_encryptor: RTL and testbench

- RSA encryption engine: computes c = m^e mod n on 16-bit plaintext words and writes each ciphertext word to the 18-bit-addressed data memory.
- Write addresses increment sequentially from 0.
- It is the producer side of the memory image consumed by MODEX_Processor, which decrypts word-by-word by address.
- The modular multiplier is sequential interleaved shift-subtract; there is no divider or `%` operator.

---
 rtl/modex_encryptor_if.sv | 30 +++
 rtl/modex_encryptor.sv | 159 +++++++++++++++
 tb/tb_modex_encryptor.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/modex_encryptor_if.sv
// Plaintext handshake and ciphertext memory-write bundle for modex_encryptor.
// Handshake: a word transfers on the rising clk edge where in_valid && in_ready; the master holds
// plain/exp_e/mod_n stable while in_valid is high, and in_ready never depends on in_valid.
interface modex_encryptor_if #(
    parameter int ADDR  = 18,
    parameter int ARQ   = 16,
    parameter int EXP_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [ARQ-1:0]   plain;
    logic [EXP_W-1:0] exp_e;
    logic [ARQ-1:0]   mod_n;
    logic             wr_en;
    logic [ADDR-1:0]  wr_addr;
    logic [ARQ-1:0]   wr_data;
    logic             busy;
    logic             err;
    logic             mem_full;

    modport master (
        output in_valid, plain, exp_e, mod_n,
        input  in_ready, wr_en, wr_addr, wr_data, busy, err, mem_full
    );

    modport slave (
        input  in_valid, plain, exp_e, mod_n,
        output in_ready, wr_en, wr_addr, wr_data, busy, err, mem_full
    );
endinterface

// File: rtl/modex_encryptor.sv
// RSA encryption engine: c = m^e mod n via LSB-first square-and-multiply over interleaved
// shift-subtract modular multipliers. Optional macro MODEX_ENC_WRAP_EN makes the write address wrap.
module modex_encryptor #(
    parameter int ADDR  = 18,
    parameter int ARQ   = 16,
    parameter int EXP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    modex_encryptor_if.slave bus,
    output logic [2:0]       dbg_state
);
    localparam int BW = (ARQ > 1) ? $clog2(ARQ) : 1;
    localparam int PW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam int AW = ARQ + 2;
    localparam logic [BW-1:0]   BIT_TOP   = BW'(ARQ - 1);
    localparam logic [PW-1:0]   PASS_TOP  = PW'(EXP_W - 1);
    localparam logic [ADDR-1:0] ADDR_LAST = {ADDR{1'b1}};

    typedef enum logic [2:0] {IDLE, CHECK, REDUCE, EXP, WRITE} state_t;

    state_t           state, next_state;
    logic [ARQ-1:0]   m_q, n_q, base_q, res_q, acc0_q, acc1_q;
    logic [EXP_W-1:0] e_q;
    logic [BW-1:0]    bit_idx;
    logic [PW-1:0]    pass_idx;
    logic [ADDR-1:0]  addr_q, wr_addr_q;
    logic [ARQ-1:0]   wr_data_q;
    logic             wr_en_q, err_q;
    logic             mem_full_w, accept, n_bad, last_bit, first_bit;
    logic [ARQ-1:0]   a1, b1, acc0_nx, acc1_nx;

    // One multiplier bit: acc stays < n, so ARQ+2 bits cover 2*acc and acc+b without overflow.
    function automatic logic [ARQ-1:0] mm_step(input logic [ARQ-1:0] acc, input logic abit,
                                               input logic [ARQ-1:0] b, input logic [ARQ-1:0] n);
        logic [AW-1:0] t;
        logic [AW-1:0] nn;
        nn = {2'b00, n};
        t  = {1'b0, acc, 1'b0};
        if (t >= nn) t = t - nn;
        if (abit) begin
            t = t + {2'b00, b};
            if (t >= nn) t = t - nn;
        end
        return ARQ'(t);
    endfunction

`ifdef MODEX_ENC_WRAP_EN
    assign mem_full_w = 1'b0;
`else
    logic mem_full_q;
    assign mem_full_w = mem_full_q;
`endif

    assign last_bit  = (bit_idx == '0);
    assign first_bit = (bit_idx == BIT_TOP);
    assign n_bad     = (n_q < ARQ'(2));
    assign accept    = bus.in_valid && bus.in_ready;

    // Multiplier 1 computes m mod n during REDUCE and base^2 during EXP; multiplier 0 result*base.
    assign a1      = (state == REDUCE) ? m_q : base_q;
    assign b1      = (state == REDUCE) ? ARQ'(1) : base_q;
    assign acc0_nx = mm_step(first_bit ? '0 : acc0_q, res_q[bit_idx], base_q, n_q);
    assign acc1_nx = mm_step(first_bit ? '0 : acc1_q, a1[bit_idx], b1, n_q);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CHECK;
            CHECK:   next_state = n_bad ? IDLE : REDUCE;
            REDUCE:  if (last_bit) next_state = EXP;
            EXP:     if (last_bit && (pass_idx == PASS_TOP)) next_state = WRITE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            e_q       <= '0;
            n_q       <= '0;
            base_q    <= '0;
            res_q     <= '0;
            acc0_q    <= '0;
            acc1_q    <= '0;
            bit_idx   <= '0;
            pass_idx  <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
`ifndef MODEX_ENC_WRAP_EN
            mem_full_q <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_q <= bus.plain;
                        e_q <= bus.exp_e;
                        n_q <= bus.mod_n;
                    end
                end
                CHECK: begin
                    err_q    <= n_bad;
                    res_q    <= ARQ'(1);
                    bit_idx  <= BIT_TOP;
                    pass_idx <= '0;
                end
                REDUCE: begin
                    acc1_q  <= acc1_nx;
                    bit_idx <= last_bit ? BIT_TOP : bit_idx - 1'b1;
                    if (last_bit) base_q <= acc1_nx;
                end
                EXP: begin
                    acc0_q  <= acc0_nx;
                    acc1_q  <= acc1_nx;
                    bit_idx <= last_bit ? BIT_TOP : bit_idx - 1'b1;
                    // Both products commit together at the end of the pass, so each reads the old base.
                    if (last_bit) begin
                        if (e_q[pass_idx]) res_q <= acc0_nx;
                        base_q   <= acc1_nx;
                        pass_idx <= pass_idx + 1'b1;
                    end
                end
                WRITE: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= addr_q;
                    wr_data_q <= res_q;
`ifdef MODEX_ENC_WRAP_EN
                    addr_q <= addr_q + 1'b1;
`else
                    if (addr_q == ADDR_LAST) mem_full_q <= 1'b1;
                    else                     addr_q     <= addr_q + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready = !rst && (state == IDLE) && !mem_full_w;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = (state != IDLE);
    assign bus.err      = err_q;
    assign bus.mem_full = mem_full_w;
    assign dbg_state    = state;
endmodule

// File: tb/tb_modex_encryptor.sv
// Bench for modex_encryptor: %-based modexp model, per-cycle compare of write/err/busy timing,
// plus a second instance with ADDR=2 for the address-end behaviour.
`timescale 1ns/1ps
module tb_modex_encryptor;
    localparam int ADDR  = 18;
    localparam int ADDR2 = 2;
    localparam int ARQ   = 16;
    localparam int EXP_W = 16;
    localparam int LAT   = 2 + ARQ * (EXP_W + 1);
    localparam int PERIOD = 3 + ARQ * (EXP_W + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    modex_encryptor_if #(.ADDR(ADDR),  .ARQ(ARQ), .EXP_W(EXP_W)) bus ();
    modex_encryptor_if #(.ADDR(ADDR2), .ARQ(ARQ), .EXP_W(EXP_W)) bus2 ();
    logic [2:0] dbg, dbg2;

    modex_encryptor #(.ADDR(ADDR),  .ARQ(ARQ), .EXP_W(EXP_W)) dut  (.clk(clk), .rst(rst), .bus(bus),  .dbg_state(dbg));
    modex_encryptor #(.ADDR(ADDR2), .ARQ(ARQ), .EXP_W(EXP_W)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .dbg_state(dbg2));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Square-and-multiply with the % operator; valid for n >= 2.
    function automatic logic [15:0] model_c(input longint m, input longint e, input longint n);
        longint r;
        longint b;
        r = 1;
        b = m % n;
        for (int k = 0; k < EXP_W; k++) begin
            if (((e >> k) & 1) == 1) r = (r * b) % n;
            b = (b * b) % n;
        end
        return r[15:0];
    endfunction

    // Scoreboard state
    logic [ADDR+ARQ-1:0]  exp_q[$];
    int                   due_q[$];
    logic [ADDR2+ARQ-1:0] exp2_q[$];
    int exp_addr  = 0;
    int exp2_addr = 0;
    int win_lo = -10;
    int win_hi = -10;
    int err_due = -10;
    logic exp_we;

    always @(negedge clk) begin
        if (!rst) begin
            exp_we = (due_q.size() > 0) && (due_q[0] == cyc);
            if (bus.wr_en || exp_we) begin
                chk("wr_en", bus.wr_en, exp_we);
                if (exp_we) begin
                    if (bus.wr_en) chk("wr_word", {bus.wr_addr, bus.wr_data}, exp_q[0]);
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end
            end
            chk("err", bus.err, (cyc == err_due));
            if (cyc >= win_lo && cyc <= win_hi)
                chk("busy_window", {bus.busy, bus.in_ready}, 2'b10);
            else if (cyc == win_hi + 1)
                chk("ready_after", {bus.busy, bus.in_ready}, 2'b01);
            if (bus2.wr_en) begin
                if (exp2_q.size() == 0) chk("wr2_unexpected", 1, 0);
                else chk("wr2_word", {bus2.wr_addr, bus2.wr_data}, exp2_q.pop_front());
            end
        end
    end

    task automatic flush();
        exp_q.delete();
        due_q.delete();
        exp2_q.delete();
        exp_addr  = 0;
        exp2_addr = 0;
        win_lo  = -10;
        win_hi  = -10;
        err_due = -10;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        flush();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [15:0] m, input logic [15:0] e, input logic [15:0] n, output int acc);
        int k;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.plain = m;
        bus.exp_e = e;
        bus.mod_n = n;
        k = 0;
        while (!bus.in_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            acc = -1;
        end else begin
            acc = cyc + 1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            win_lo = acc;
            if (n < 2) begin
                err_due = acc + 1;
                win_hi  = acc;
            end else begin
                exp_q.push_back({ADDR'(exp_addr), model_c(m, e, n)});
                due_q.push_back(acc + LAT);
                exp_addr++;
                win_hi = acc + LAT - 1;
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (due_q.size() > 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (due_q.size() > 0) chk("drain_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, acc, k, accepted;
        logic [15:0] v2m[5];
        logic [15:0] v2e[5];
        logic [15:0] v2n[5];

        bus.in_valid = 1'b0;  bus.plain = '0;  bus.exp_e = '0;  bus.mod_n = '0;
        bus2.in_valid = 1'b0; bus2.plain = '0; bus2.exp_e = '0; bus2.mod_n = '0;

        // Pin the model to hand-computed values
        chk("model_rsa_enc", model_c(65, 17, 3233), 2790);
        chk("model_rsa_dec", model_c(2790, 2753, 3233), 65);
        chk("model_reduce", model_c(3300, 1, 3233), 67);
        chk("model_e0", model_c(5, 0, 7), 1);
        chk("model_m0", model_c(0, 3, 7), 0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.err, bus.mem_full, bus.in_ready}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_wr_en", bus.wr_en, 0);

        // Basic encrypt: 2790 at addr 0, exactly LAT edges after accept
        send(16'd65, 16'd17, 16'd3233, acc);
        drain();

        // Back-to-back
        do_reset();
        send(16'd2790, 16'd2753, 16'd3233, a1);
        send(16'd65, 16'd17, 16'd3233, a2);
        chk("throughput", a2 - a1, PERIOD);
        drain();

        // Reduction and edge operands
        send(16'd5, 16'd0, 16'd7, acc);
        send(16'd0, 16'd3, 16'd7, acc);
        send(16'd3300, 16'd1, 16'd3233, acc);
        send(16'd1234, 16'hFFFF, 16'd65521, acc);
        send(16'd65534, 16'd3, 16'd65535, acc);
        send(16'd65535, 16'd65535, 16'd2, acc);
        drain();

        // Reset mid-operation
        send(16'd65, 16'd17, 16'd3233, acc);
        while (cyc < acc + 100) @(negedge clk);
        rst = 1'b1;
        flush();
        #1;
        chk("midrst_outputs", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.err, bus.mem_full, bus.in_ready}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(16'd65, 16'd17, 16'd3233, acc);
        drain();

        // Invalid modulus: err pulse, no write, no address step
        do_reset();
        send(16'd9, 16'd3, 16'd1, acc);
        send(16'd7, 16'd7, 16'd0, acc);
        send(16'd2790, 16'd2753, 16'd3233, acc);
        drain();
        chk("main_queue_empty", exp_q.size(), 0);

        // Address end on the ADDR=2 instance
        do_reset();
        v2m = '{16'd65, 16'd5, 16'd0, 16'd3300, 16'd2790};
        v2e = '{16'd17, 16'd0, 16'd3, 16'd1, 16'd2753};
        v2n = '{16'd3233, 16'd7, 16'd7, 16'd3233, 16'd3233};
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1;
            bus2.plain = v2m[i];
            bus2.exp_e = v2e[i];
            bus2.mod_n = v2n[i];
            k = 0;
            while (!bus2.in_ready && k < 400) begin
                @(negedge clk);
                k++;
            end
            if (bus2.in_ready) begin
                accepted++;
                @(posedge clk);
                #1;
                bus2.in_valid = 1'b0;
                exp2_q.push_back({ADDR2'(exp2_addr), model_c(v2m[i], v2e[i], v2n[i])});
                exp2_addr = (exp2_addr + 1) % 4;
            end else begin
                bus2.in_valid = 1'b0;
            end
        end
        repeat (300) @(negedge clk);
        chk("addr2_writes_done", exp2_q.size(), 0);
`ifdef MODEX_ENC_WRAP_EN
        chk("addr2_accepted", accepted, 5);
        chk("addr2_mem_full", bus2.mem_full, 0);
        chk("addr2_in_ready", bus2.in_ready, 1);
`else
        chk("addr2_accepted", accepted, 4);
        chk("addr2_mem_full", bus2.mem_full, 1);
        chk("addr2_in_ready", bus2.in_ready, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
